// File: rtl/round_ctrl_pkg.sv
// Shared types and constants for the round controller slice (package game_pkg).
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHOW   = 3'd1,
    S_INPUT  = 3'd2,
    S_CHECK  = 3'd3,
    S_RESULT = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  localparam int unsigned SCORE_W  = 8;
  localparam int unsigned LIVES_W  = 2;
  localparam logic [7:0]  LED_HIT  = 8'hFF;
  localparam logic [7:0]  LED_MISS = 8'h00;
  localparam logic [7:0]  LED_OVER = 8'h81;

  // Fibonacci step for x^8+x^6+x^5+x^4+1; a non-zero state never maps to zero.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/round_ctrl_if.sv
// Player/display signal bundle between the round controller and its board glue.
interface round_ctrl_if;
  import game_pkg::*;

  logic               TICK;
  logic               BTN;
  logic [7:0]         SWITCHES;
  logic [7:0]         LED;
  logic [SCORE_W-1:0] SCORE;
  logic [LIVES_W-1:0] LIVES;
  logic [2:0]         STATE;

  modport master (output TICK, BTN, SWITCHES, input LED, SCORE, LIVES, STATE);
  modport slave  (input TICK, BTN, SWITCHES, output LED, SCORE, LIVES, STATE);
endinterface

// File: rtl/round_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR that supplies the round target patterns.
module lfsr8
  import game_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic [7:0] SEED,
  output logic [7:0] Q
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)  Q <= SEED;
    else if (EN) Q <= lfsr8_next(Q);
  end

endmodule

// File: rtl/round_ctrl.sv
// Memory-pattern round controller: show target, take entry, score, lives.
// Define ROUND_CTRL_TIMEOUT_EN to turn an unanswered INPUT phase into a miss.
module round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned SHOW_TICKS   = 500,
  parameter int unsigned INPUT_TICKS  = 5000,
  parameter int unsigned RESULT_TICKS = 250,
  parameter int unsigned LIVES_INIT   = 3,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input logic         CLK,
  input logic         RST_N,
  round_ctrl_if.slave io
);

  localparam int unsigned MAX_SR    = (SHOW_TICKS > RESULT_TICKS) ? SHOW_TICKS : RESULT_TICKS;
  localparam int unsigned MAX_TICKS = (MAX_SR > INPUT_TICKS) ? MAX_SR : INPUT_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);

  state_t             state;
  logic [7:0]         led;
  logic [SCORE_W-1:0] score;
  logic [LIVES_W-1:0] lives;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [7:0]         target;
  logic [7:0]         captured;
  logic               timed_out;
  logic [7:0]         lfsr_q;
  logic               lfsr_en;
  logic               reseed;
  logic               hit;

  logic       btn_s0, btn_s1, btn_s2;
  logic [1:0] sync_vld;
  logic       btn_rise;

  // btn_s2 is the edge-detect history, held high until btn_s1 carries a
  // post-reset sample so a button held through reset release is not an edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_s0   <= 1'b0;
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b1;
      sync_vld <= '0;
    end else begin
      btn_s0   <= io.BTN;
      btn_s1   <= btn_s0;
      btn_s2   <= btn_s1 | ~sync_vld[1];
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  assign btn_rise = btn_s1 & ~btn_s2;
  assign cnt_inc  = cnt + 1'b1;
  assign hit      = (captured == target) && !timed_out;
  assign reseed   = (state == S_RESULT) && io.TICK &&
                    (cnt_inc == CNT_W'(RESULT_TICKS)) && (lives != '0);
  assign lfsr_en  = (state == S_IDLE) || reseed;

  lfsr8 u_lfsr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (lfsr_en),
    .SEED  (LFSR_SEED),
    .Q     (lfsr_q)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      led       <= '0;
      score     <= '0;
      lives     <= LIVES_W'(LIVES_INIT);
      cnt       <= '0;
      target    <= '0;
      captured  <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          led <= '0;
          if (btn_rise) begin
            state  <= S_SHOW;
            score  <= '0;
            lives  <= LIVES_W'(LIVES_INIT);
            target <= lfsr_q;
            led    <= lfsr_q;
            cnt    <= '0;
          end
        end
        S_SHOW: begin
          if (io.TICK) begin
            if (cnt_inc == CNT_W'(SHOW_TICKS)) begin
              state <= S_INPUT;
              cnt   <= '0;
              led   <= io.SWITCHES;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_INPUT: begin
          led <= io.SWITCHES;
          if (btn_rise) begin
            state     <= S_CHECK;
            captured  <= io.SWITCHES;
            timed_out <= 1'b0;
          end
`ifdef ROUND_CTRL_TIMEOUT_EN
          else if (io.TICK) begin
            if (cnt_inc == CNT_W'(INPUT_TICKS)) begin
              state     <= S_CHECK;
              timed_out <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
`endif
        end
        S_CHECK: begin
          state <= S_RESULT;
          cnt   <= '0;
          if (hit) begin
            led <= LED_HIT;
            if (score != '1) score <= score + 1'b1;
          end else begin
            led   <= LED_MISS;
            lives <= lives - 1'b1;
          end
        end
        S_RESULT: begin
          if (io.TICK) begin
            if (cnt_inc == CNT_W'(RESULT_TICKS)) begin
              cnt <= '0;
              if (lives == '0) begin
                state <= S_OVER;
                led   <= LED_OVER;
              end else begin
                // Target takes the value the LFSR steps to on this same edge.
                state  <= S_SHOW;
                target <= lfsr8_next(lfsr_q);
                led    <= lfsr8_next(lfsr_q);
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_OVER: begin
          led <= LED_OVER;
          if (btn_rise) begin
            state <= S_IDLE;
            led   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.LED   = led;
  assign io.SCORE = score;
  assign io.LIVES = lives;
  assign io.STATE = state;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed-sequence bench for round_ctrl with randomized entries and an
// abstract game model (target sequence, score, lives, tick counts).
module tb_round_ctrl;
  import game_pkg::*;

  localparam int unsigned SHOW_T   = 4;
  localparam int unsigned INPUT_T  = 8;
  localparam int unsigned RESULT_T = 2;
  localparam int unsigned LIVES0   = 3;
  localparam logic [7:0]  SEED     = 8'hA5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick  = 1'b0;
  logic       btn   = 1'b0;
  logic [7:0] sw    = '0;

  round_ctrl_if bus ();
  assign bus.TICK     = tick;
  assign bus.BTN      = btn;
  assign bus.SWITCHES = sw;

  round_ctrl #(
    .SHOW_TICKS   (SHOW_T),
    .INPUT_TICKS  (INPUT_T),
    .RESULT_TICKS (RESULT_T),
    .LIVES_INIT   (LIVES0),
    .LFSR_SEED    (SEED)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ticks_total = 0;
  int mark  = 0;

  // cyc = number of rising edges so far; TICK lands on edges whose index is a multiple of 4
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (tick) ticks_total <= ticks_total + 1;
  always @(negedge clk) tick = (cyc % 4 == 3);

  logic [7:0] m_lfsr;
  logic [7:0] m_target;
  int         m_idle_from;
  int         m_score;
  int         m_lives;

  function automatic logic [7:0] adv(input logic [7:0] v, input int n);
    logic [7:0] x = v;
    for (int i = 0; i < n; i++) x = {x[6:0], ^(x & 8'hB8)};
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_exit(input logic [2:0] from, input string tag);
    int n = 0;
    while (bus.STATE === from && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_exit"}, 32'(bus.STATE !== from), 32'd1);
  endtask

  task automatic press(output int e);
    @(negedge clk);
    btn = 1'b1;
    e = cyc + 3;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_btn();
    @(negedge clk);
    btn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_game();
    int e;
    press(e);
    m_target = adv(m_lfsr, e - m_idle_from);
    m_lfsr   = adv(m_target, 1);
    m_score  = 0;
    m_lives  = LIVES0;
    chk("start_state", bus.STATE, S_SHOW);
    chk("start_led", bus.LED, m_target);
    chk("start_score", bus.SCORE, 0);
    chk("start_lives", bus.LIVES, LIVES0);
    mark = ticks_total;
    release_btn();
  endtask

  task automatic show_phase(input bit poke);
    int e;
    if (poke) begin
      press(e);
      chk("show_btn_state", bus.STATE, S_SHOW);
      chk("show_btn_score", bus.SCORE, m_score);
      release_btn();
    end
    chk("show_led", bus.LED, m_target);
    wait_exit(S_SHOW, "show");
    chk("show_next", bus.STATE, S_INPUT);
    chk("show_ticks", ticks_total - mark, SHOW_T);
    chk("input_led0", bus.LED, sw);
    mark = ticks_total;
  endtask

  task automatic finish_entry(input bit hit);
    @(posedge clk); #1;
    if (hit) m_score = (m_score < 255) ? m_score + 1 : 255;
    else     m_lives = m_lives - 1;
    chk("result_state", bus.STATE, S_RESULT);
    chk("result_score", bus.SCORE, m_score);
    chk("result_lives", bus.LIVES, m_lives);
    chk("result_led", bus.LED, hit ? 8'hFF : 8'h00);
    mark = ticks_total;
  endtask

  task automatic input_phase(input bit hit, input bit poke_result);
    logic [7:0] junk;
    logic [7:0] entry;
    int e;
    junk  = 8'($urandom);
    entry = hit ? m_target : (m_target ^ 8'($urandom_range(1, 255)));
    @(negedge clk);
    sw = junk;
    @(posedge clk); #1;
    chk("input_led_follow", bus.LED, junk);
    @(negedge clk);
    sw = entry;
    press(e);
    chk("check_state", bus.STATE, S_CHECK);
    finish_entry(hit);
    if (poke_result) begin
      @(negedge clk);
      btn = 1'b0;
      @(negedge clk);
      btn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("result_btn_state", bus.STATE, S_RESULT);
      chk("result_btn_score", bus.SCORE, m_score);
    end else begin
      release_btn();
    end
  endtask

  task automatic result_phase();
    wait_exit(S_RESULT, "result");
    chk("result_ticks", ticks_total - mark, RESULT_T);
    if (m_lives == 0) begin
      chk("over_state", bus.STATE, S_OVER);
      chk("over_led", bus.LED, 8'h81);
    end else begin
      m_lfsr   = adv(m_lfsr, 1);
      m_target = m_lfsr;
      chk("reshow_state", bus.STATE, S_SHOW);
      chk("reshow_led", bus.LED, m_target);
    end
    mark = ticks_total;
    release_btn();
  endtask

  task automatic round(input bit hit, input bit ps, input bit pr);
    show_phase(ps);
    input_phase(hit, pr);
    result_phase();
  endtask

  task automatic over_to_idle();
    int e;
    repeat (12) @(posedge clk);
    #1;
    chk("over_hold_state", bus.STATE, S_OVER);
    chk("over_hold_led", bus.LED, 8'h81);
    chk("over_hold_score", bus.SCORE, m_score);
    chk("over_hold_lives", bus.LIVES, 0);
    press(e);
    chk("idle_state", bus.STATE, S_IDLE);
    chk("idle_led", bus.LED, 8'h00);
    chk("idle_score", bus.SCORE, m_score);
    m_idle_from = e + 1;
    release_btn();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    int ein;
    int eexp;

    repeat (3) @(negedge clk);
    chk("reset_state", bus.STATE, S_IDLE);
    chk("reset_led", bus.LED, 8'h00);
    chk("reset_score", bus.SCORE, 0);
    chk("reset_lives", bus.LIVES, LIVES0);
    rst_n = 1'b1;
    r = cyc;
    m_lfsr = SEED;
    m_idle_from = r + 1;
    repeat ($urandom_range(3, 10)) @(negedge clk);
    chk("idle_led_pre", bus.LED, 8'h00);

    // First game: directed hits with presses in SHOW and RESULT, then random play to game over
    start_game();
    round(1'b1, 1'b1, 1'b0);
    chk("first_hit_score", bus.SCORE, 1);
    round(1'b1, 1'b0, 1'b1);
    n = 0;
    while (m_lives > 0) begin
      round((n < 12) ? 1'($urandom % 2) : 1'b0, 1'($urandom % 2), 1'($urandom % 2));
      n++;
    end
    over_to_idle();

    // Second game: three straight misses
    start_game();
    for (int i = 0; i < 3; i++) round(1'b0, 1'b0, 1'b0);
    chk("three_miss_lives", bus.LIVES, 0);
    over_to_idle();

    start_game();
`ifdef ROUND_CTRL_TIMEOUT_EN
    show_phase(1'b0);
    wait_exit(S_INPUT, "timeout");
    chk("timeout_state", bus.STATE, S_CHECK);
    chk("timeout_ticks", ticks_total - mark, INPUT_T);
    finish_entry(1'b0);
    result_phase();

    show_phase(1'b0);
    ein  = cyc;
    eexp = ((ein / 4) + 1) * 4 + 4 * (INPUT_T - 1);
    @(negedge clk);
    sw = m_target;
    while (cyc < eexp - 3) @(negedge clk);
    btn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("expiry_edge", cyc, eexp);
    chk("expiry_state", bus.STATE, S_CHECK);
    finish_entry(1'b1);
    result_phase();
`else
    show_phase(1'b0);
    repeat (60) @(posedge clk);
    #1;
    chk("input_wait_state", bus.STATE, S_INPUT);
    chk("input_wait_lives", bus.LIVES, LIVES0);
    input_phase(1'b1, 1'b0);
    result_phase();
`endif

    // Asynchronous reset mid-round with the button held through release
    show_phase(1'b0);
    chk("pre_reset_score", 32'(bus.SCORE != 0), 1);
    @(negedge clk);
    btn = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", bus.STATE, S_IDLE);
    chk("async_rst_led", bus.LED, 8'h00);
    chk("async_rst_score", bus.SCORE, 0);
    chk("async_rst_lives", bus.LIVES, LIVES0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    repeat (10) @(posedge clk);
    #1;
    chk("held_btn_state", bus.STATE, S_IDLE);
    chk("held_btn_led", bus.LED, 8'h00);
    @(negedge clk);
    btn = 1'b0;
    m_lfsr = SEED;
    m_idle_from = r + 1;
    repeat (2) @(negedge clk);

    // Score saturation
    start_game();
    for (int i = 0; i < 256; i++) round(1'b1, 1'b0, 1'b0);
    chk("sat_score", bus.SCORE, 255);
    chk("sat_lives", bus.LIVES, LIVES0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 Parameter SHOW_TICKS, default 500: TICK pulses the target pattern is displayed.
REQ-002 Parameter INPUT_TICKS, default 5000: TICK pulses allowed for player entry (timeout build only).
REQ-003 Parameter RESULT_TICKS, default 250: TICK pulses the hit/miss indication is held.
REQ-004 Parameter LIVES_INIT, default 3: lives at game start, range 1..3.
REQ-005 Parameter LFSR_SEED, default 8'hA5: non-zero LFSR reset value.
REQ-006 CLK  in  1  system clock; the only clock.
REQ-007 RST_N  in  1  asynchronous active-low reset.
REQ-008 TICK  in  1  one-CLK-wide timing enable from the clock divider.
REQ-009 BTN  in  1  raw player button, asynchronous to CLK.
REQ-010 SWITCHES  in  8  player pattern entry.
REQ-011 LED  out  8  active-high pattern/result display.
REQ-012 SCORE  out  8  rounds won this game, to the score display.
REQ-013 LIVES  out  2  remaining lives.
REQ-014 STATE  out  3  current state encoding, for debug LEDs.

Function
REQ-015 BTN shall pass a 2-flop synchronizer; btn_rise shall be high for one CLK on the synchronized 0->1 edge, two CLKs after the input rises.
REQ-016 States shall be IDLE, SHOW, INPUT, CHECK, RESULT, OVER.
REQ-017 IDLE: LFSR advances every CLK; btn_rise -> SHOW, SCORE<=0, LIVES<=LIVES_INIT, target<=current LFSR value, tick counter<=0.
REQ-018 SHOW: LED=target; counter increments on TICK; on the TICK that makes count==SHOW_TICKS -> INPUT, counter<=0.
REQ-019 INPUT: LED=SWITCHES; btn_rise -> CHECK with SWITCHES captured that same CLK.
REQ-020 CHECK: exactly one CLK; hit if captured==target; hit -> SCORE+1 saturating at 255; miss -> LIVES-1; then -> RESULT.
REQ-021 RESULT: LED=8'hFF after hit, 8'h00 after miss; held RESULT_TICKS TICKs; then LIVES==0 -> OVER, else -> SHOW with LFSR advanced one step and target<=new value.
REQ-022 OVER: LED=8'h81; SCORE and LIVES frozen; btn_rise -> IDLE.
REQ-023 LED shall be 8'h00 in IDLE.
REQ-024 LFSR shall be 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, never reaching 8'h00.
REQ-025 btn_rise outside IDLE, INPUT, OVER shall be ignored.
REQ-026 TICK shall be ignored in IDLE, INPUT (non-timeout build), CHECK, OVER.
REQ-027 Outputs shall be registered; SCORE/LIVES update the CLK after CHECK.

Reset
REQ-028 RST_N low shall force IDLE, LED=0, SCORE=0, LIVES=LIVES_INIT, counter=0, LFSR=LFSR_SEED, synchronizer flops=0 immediately, mid-round included.
REQ-029 A BTN held high across reset release shall not produce btn_rise.

Configuration
REQ-030 Macro ROUND_CTRL_TIMEOUT_EN defined: INPUT counts TICKs; reaching INPUT_TICKS is a miss (-> CHECK forced mismatch); btn_rise on the same CLK as expiry wins and is compared normally.
REQ-031 Macro undefined: INPUT waits indefinitely for btn_rise; INPUT_TICKS unused.

Structure
REQ-032 Package game_pkg shall hold the state enum (3-bit), SCORE_W=8, LIVES_W=2, LED_HIT/LED_MISS/LED_OVER constants.
REQ-033 Sub-module lfsr8 (CLK, RST_N, EN, SEED, Q) shall implement the LFSR.

Verification (SHOW_TICKS=4, INPUT_TICKS=8, RESULT_TICKS=2, LIVES_INIT=3, TICK every 4 CLK)
REQ-034 Reset, press BTN in IDLE -> SHOW, LED=target for 4 TICKs, then INPUT; SWITCHES=target, press -> SCORE=1, LED=8'hFF for 2 TICKs, new target in SHOW.
REQ-035 Three wrong entries -> LIVES 3,2,1,0, LED=8'h00 each RESULT, then OVER with LED=8'h81; press -> IDLE; press -> SCORE=0, LIVES=3.
REQ-036 SCORE preloaded to 255 path (force 256 hits via fast params) -> SCORE stays 255.
REQ-037 TIMEOUT_EN: no press for 8 TICKs -> LIVES-1; press on expiry CLK with correct SWITCHES -> hit.
REQ-038 RST_N pulsed low in INPUT -> IDLE, LED=0, SCORE=0 asynchronously; BTN held through release -> stays IDLE.
REQ-039 BTN pressed during SHOW/RESULT -> no state change, no score change.
